// File: rtl/demux_deser_8_pkg.sv
// Shared constants for the 8:1 select-mux path: lane count, select width and lane slicing.
package demux_deser_8_pkg;

    localparam int LANES  = 8;
    localparam int SLOT_W = 3;

    localparam logic [SLOT_W-1:0] SLOT_FIRST = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_AFTER_SOF = 3'd1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = 3'd7;

    function automatic int lane_base(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/demux_deser_8_slot_decoder_3to8.sv
// 3-to-8 one-hot decoder: turns the slot index into a per-lane write enable.
module slot_decoder_3to8
    import demux_deser_8_pkg::*;
(
    input  logic [SLOT_W-1:0] slot_i,
    input  logic              en_i,
    output logic [LANES-1:0]  we_o
);

    // One-hot lane enable, all-zero when no beat is accepted
    always_comb begin
        we_o = {LANES{1'b0}};
        if (en_i) begin
            we_o[slot_i] = 1'b1;
        end else begin
            we_o = {LANES{1'b0}};
        end
    end

endmodule

// File: rtl/demux_deser_8.sv
// Receive side of the 8:1 select-mux path: rebuilds an 8-lane word from a serial lane
// stream into an assembly register, then hands it to a double-buffered output register.
module demux_deser_8
    import demux_deser_8_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [W-1:0]         din,
    input  logic                 din_sof,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [LANES*W-1:0]   q,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic [SLOT_W-1:0]    slot,
    output logic                 sof_err
);

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [LANES*W-1:0] asm_q, asm_d;
    logic               asm_full_q, asm_full_d;
    logic [LANES*W-1:0] q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic               sof_err_q, sof_err_d;

    logic               accept_s;
    logic               complete_s;
    logic               q_free_s;
    logic               drain_s;
    logic [SLOT_W-1:0]  wr_slot_s;
    logic [LANES-1:0]   lane_we_s;

    assign accept_s   = din_valid && !asm_full_q;
    assign wr_slot_s  = din_sof ? SLOT_FIRST : slot_q;
    // A SOF landing on slot 7 restarts the word instead of completing it
    assign complete_s = accept_s && !din_sof && (slot_q == SLOT_LAST);
    assign q_free_s   = !q_valid_q || q_ready;
    assign drain_s    = q_valid_q && q_ready;

    slot_decoder_3to8 u_slot_decoder (
        .slot_i (wr_slot_s),
        .en_i   (accept_s),
        .we_o   (lane_we_s)
    );

    // Assembly register: merge the accepted beat into its lane
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_we_s[k]) begin
                asm_d[lane_base(k, W) +: W] = din;
            end else begin
                asm_d[lane_base(k, W) +: W] = asm_q[lane_base(k, W) +: W];
            end
        end
    end

    // Slot counter, word hand-off, drain and SOF error detection
    always_comb begin
        slot_d     = slot_q;
        asm_full_d = asm_full_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        sof_err_d  = accept_s && din_sof && (slot_q != SLOT_FIRST);

        if (accept_s) begin
            slot_d = din_sof ? SLOT_AFTER_SOF : slot_q + 3'd1;
        end else begin
            slot_d = slot_q;
        end

        if (complete_s) begin
            if (q_free_s) begin
                q_d       = asm_d;
                q_valid_d = 1'b1;
            end else begin
                asm_full_d = 1'b1;
            end
        end else if (drain_s) begin
            if (asm_full_q) begin
                q_d        = asm_q;
                asm_full_d = 1'b0;
            end else begin
                q_valid_d = 1'b0;
            end
        end else begin
            q_d = q_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= SLOT_FIRST;
            asm_q      <= {(LANES*W){1'b0}};
            asm_full_q <= 1'b0;
            q_q        <= {(LANES*W){1'b0}};
            q_valid_q  <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            asm_q      <= asm_d;
            asm_full_q <= asm_full_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            sof_err_q  <= sof_err_d;
        end
    end

    assign din_ready = !asm_full_q;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign slot      = slot_q;
    assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_demux_deser_8.sv
// Self-checking bench for demux_deser_8: scoreboard of expected words plus vector table.
module tb_demux_deser_8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       din1, sof1, valid1, ready1, qv1, qr1, serr1;
    logic [7:0] q1;
    logic [2:0] slot1;
    logic [3:0] din4;
    logic       sof4, valid4, ready4, qv4, qr4, serr4;
    logic [31:0] q4;
    logic [2:0] slot4;

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;
    int stalls   = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;
    logic [7:0] m_asm;
    logic [2:0] m_slot;

    demux_deser_8 #(.W(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .din(din1), .din_sof(sof1), .din_valid(valid1),
        .din_ready(ready1), .q(q1), .q_valid(qv1), .q_ready(qr1), .slot(slot1), .sof_err(serr1)
    );

    demux_deser_8 #(.W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .din(din4), .din_sof(sof4), .din_valid(valid4),
        .din_ready(ready4), .q(q4), .q_valid(qv4), .q_ready(qr4), .slot(slot4), .sof_err(serr4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transferred word must match the oldest expected word
    always @(negedge clk) begin
        if (reset_n && qv1 && qr1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got word 0x%0h expected none", q1);
            end else begin
                sb_exp = sb_q.pop_front();
                n_words++;
                check("sb_word", 32'(q1), 32'(sb_exp));
            end
        end
    end

    // Drive one beat, wait (bounded) for acceptance, update the reference model
    task automatic send(input logic d, input logic s);
        int w;
        logic exp_err;
        logic [2:0] ws;
        din1 = d; sof1 = s; valid1 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!ready1 && w < 64) begin
            w++;
            @(negedge clk);
        end
        if (!ready1) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: din_ready got 0 expected 1");
            valid1 = 1'b0; sof1 = 1'b0;
            return;
        end
        stalls += w;
        check("slot", 32'(slot1), 32'(m_slot));
        exp_err = s && (m_slot != 3'd0);
        ws = s ? 3'd0 : m_slot;
        m_asm[ws] = d;
        if (!s && m_slot == 3'd7) sb_q.push_back(m_asm);
        m_slot = s ? 3'd1 : m_slot + 3'd1;
        @(posedge clk); #1;
        valid1 = 1'b0; sof1 = 1'b0;
        check("sof_err", 32'(serr1), 32'(exp_err));
    endtask

    task automatic send_word(input logic [7:0] bits, input logic sof_first);
        for (int i = 0; i < 8; i++) send(bits[i], sof_first && (i == 0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       d;
        logic       s;
        logic [2:0] exp_slot;
        logic       exp_qv;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] basic_bits;
    logic [7:0] bp_bits[2];
    int         words0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        din1 = 1'b0; sof1 = 1'b0; valid1 = 1'b0; qr1 = 1'b1;
        din4 = 4'd0; sof4 = 1'b0; valid4 = 1'b0; qr4 = 1'b0;
        m_slot = 3'd0; m_asm = 8'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("rst_slot", 32'(slot1), 32'd0);
        check("rst_q_valid", 32'(qv1), 32'd0);
        check("rst_din_ready", 32'(ready1), 32'd1);
        check("rst_sof_err", 32'(serr1), 32'd0);
        check("rst_q", 32'(q1), 32'd0);
        @(posedge clk); #1;

        // Basic vector table, W=1
        basic_bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            tbl[i].d        = basic_bits[i];
            tbl[i].s        = (i == 0);
            tbl[i].exp_slot = 3'(i + 1);
            tbl[i].exp_qv   = (i == 7);
        end
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].d, tbl[i].s);
            check("basic_slot", 32'(slot1), 32'(tbl[i].exp_slot));
            check("basic_q_valid", 32'(qv1), 32'(tbl[i].exp_qv));
        end
        check("basic_q", 32'(q1), 32'h4D);
        idle(1);
        check("basic_q_valid_drop", 32'(qv1), 32'd0);
        check("basic_q_hold", 32'(q1), 32'h4D);

        // Mid-word reset at slot 5
        send(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
        check("pre_rst_slot", 32'(slot1), 32'd5);
        reset_n = 1'b0;
        #2;
        check("midrst_slot", 32'(slot1), 32'd0);
        check("midrst_q_valid", 32'(qv1), 32'd0);
        check("midrst_din_ready", 32'(ready1), 32'd1);
        m_slot = 3'd0;
        @(posedge clk); #1 reset_n = 1'b1;
        words0 = n_words;
        send_word(8'hA7, 1'b0);
        idle(3);
        check("midrst_words", 32'(n_words - words0), 32'd1);

        // Backpressure: two words with q_ready low
        qr1 = 1'b0;
        bp_bits[0] = 8'h5A;
        bp_bits[1] = 8'hC3;
        words0 = n_words;
        for (int i = 0; i < 16; i++) send(bp_bits[i / 8][i % 8], i == 0);
        check("bp_q_valid", 32'(qv1), 32'd1);
        check("bp_q", 32'(q1), 32'h5A);
        check("bp_din_ready", 32'(ready1), 32'd0);
        idle(3);
        check("bp_q_stable", 32'(q1), 32'h5A);
        check("bp_slot_frozen", 32'(slot1), 32'd0);
        check("bp_still_full", 32'(ready1), 32'd0);
        qr1 = 1'b1;
        idle(1);
        check("bp_second_q", 32'(q1), 32'hC3);
        check("bp_ready_back", 32'(ready1), 32'd1);
        idle(2);
        check("bp_drained", 32'(qv1), 32'd0);
        check("bp_words", 32'(n_words - words0), 32'd2);

        // Streaming: 4 back-to-back words, no stalls allowed
        stalls = 0;
        words0 = n_words;
        for (int wd = 0; wd < 4; wd++)
            for (int b = 0; b < 8; b++)
                send(1'($urandom_range(0, 1)), (wd == 0) && (b == 0));
        idle(2);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_words", 32'(n_words - words0), 32'd4);

        // SOF resync after 3 beats, then SOF landing on slot 7
        words0 = n_words;
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("resync_slot", 32'(slot1), 32'd1);
        for (int i = 0; i < 7; i++) send(1'(i % 2), 1'b0);
        idle(1);
        send(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
        check("sof7_pre_slot", 32'(slot1), 32'd7);
        send(1'b0, 1'b1);
        check("sof7_no_word", 32'(qv1), 32'd0);
        for (int i = 0; i < 7; i++) send(1'b0, 1'b0);
        idle(3);
        check("resync_words", 32'(n_words - words0), 32'd2);

        // Wrap and width, W=4
        for (int i = 0; i < 8; i++) begin
            din4 = 4'(i); sof4 = (i == 0); valid4 = 1'b1;
            @(negedge clk);
            check("w4_slot", 32'(slot4), 32'(i));
            @(posedge clk); #1;
        end
        valid4 = 1'b0; sof4 = 1'b0;
        check("w4_slot_wrap", 32'(slot4), 32'd0);
        check("w4_q_valid", 32'(qv4), 32'd1);
        check("w4_q", q4, 32'h7654_3210);
        qr4 = 1'b1;
        idle(1);
        check("w4_drained", 32'(qv4), 32'd0);
        check("w4_q_hold", q4, 32'h7654_3210);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
